// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and the flag bundle.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_XOR  = 4'h2;
  localparam logic [3:0] OP_SLT  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_NAND = 4'h5;
  localparam logic [3:0] OP_NOR  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_MUL  = 4'h8;
  localparam logic [3:0] OP_SLL  = 4'h9;
  localparam logic [3:0] OP_SRL  = 4'hA;
  localparam logic [3:0] OP_SRA  = 4'hB;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MBUSY = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic zero;
    logic overflow;
    logic cout;
  } flags_t;

  // Opcodes 1100-1111 are reserved and yield a zero result with all flags cleared.
  function automatic logic isIllegal(input logic [3:0] op);
    return op[3] & op[2];
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between operand fetch, the ALU and writeback.
interface alu_seq_if #(parameter int WIDTH = 32);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             cout;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, overflow, cout
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, overflow, cout
  );

endinterface

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: arithmetic, logic, compare and barrel shifts with flags.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output flags_t           flags_o
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   shAmt;
  logic             ovf;
  logic             carry;

  assign sum   = {1'b0, a_i} + {1'b0, b_i};
  assign diff  = {1'b0, a_i} - {1'b0, b_i};
  assign shAmt = b_i[SHW-1:0];

  always_comb begin
    result_o = '0;
    ovf      = 1'b0;
    carry    = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_o = sum[WIDTH-1:0];
        ovf      = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
        carry    = sum[WIDTH];
      end
      OP_SUB: begin
        // The extra MSB of diff is the borrow, so its inverse means a >= b unsigned.
        result_o = diff[WIDTH-1:0];
        ovf      = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
        carry    = ~diff[WIDTH];
      end
      OP_XOR:  result_o = a_i ^ b_i;
      OP_SLT:  result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_AND:  result_o = a_i & b_i;
      OP_NAND: result_o = ~(a_i & b_i);
      OP_NOR:  result_o = ~(a_i | b_i);
      OP_OR:   result_o = a_i | b_i;
      OP_SLL:  result_o = a_i << shAmt;
      OP_SRL:  result_o = a_i >> shAmt;
      OP_SRA:  result_o = $signed(a_i) >>> shAmt;
      default: result_o = '0;
    endcase

    flags_o.zero     = !isIllegal(op_i) && (result_o == '0);
    flags_o.overflow = ovf;
    flags_o.cout     = carry;
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and a multi-cycle shift-add multiplier.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 2);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  flags_t               flags_q, flags_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [SHW-1:0]       count_q, count_d;

  logic [WIDTH-1:0]     combResult;
  flags_t               combFlags;
  logic                 accept;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op_i     (bus.op),
    .a_i      (bus.a),
    .b_i      (bus.b),
    .result_o (combResult),
    .flags_o  (combFlags)
  );

  // Upper half gains the multiplicand when the multiplier LSB is set, then the pair shifts right.
  function automatic logic [2*WIDTH-1:0] mulStep(input logic [2*WIDTH-1:0] acc,
                                                 input logic [WIDTH-1:0]   mcand);
    logic [WIDTH:0] upper;
    upper = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    return {upper, acc[WIDTH-1:1]};
  endfunction

  assign bus.in_ready  = (state_q == IDLE) || ((state_q == HOLD) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.result    = result_q;
  assign bus.zero      = flags_q.zero;
  assign bus.overflow  = flags_q.overflow;
  assign bus.cout      = flags_q.cout;

  // The accept edge already performs the first multiply step, so the W-th edge delivers the product.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    count_d  = count_q;

    case (state_q)
      MBUSY: begin
        acc_d   = mulStep(acc_q, mcand_q);
        count_d = count_q + SHW'(1);
        if (count_q == LAST_STEP) begin
          state_d          = HOLD;
          result_d         = acc_d[WIDTH-1:0];
          flags_d.zero     = (acc_d[WIDTH-1:0] == '0);
          flags_d.overflow = |acc_d[2*WIDTH-1:WIDTH];
          flags_d.cout     = 1'b0;
        end
      end
      HOLD: begin
        if (bus.out_ready && !bus.in_valid) begin
          state_d = IDLE;
        end
      end
      default: ;
    endcase

    if (accept) begin
      if (bus.op == OP_MUL) begin
        state_d = MBUSY;
        mcand_d = bus.a;
        acc_d   = mulStep({{WIDTH{1'b0}}, bus.b}, bus.a);
        count_d = '0;
      end else begin
        state_d  = HOLD;
        result_d = combResult;
        flags_d  = combFlags;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases, backpressure, mid-MUL reset and random ops.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(32)) bus32 ();
  alu_seq_if #(.WIDTH(8))  bus8 ();

  alu_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ov;
    logic        c;
    int          lat;
  } expect_t;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 64'sd1;

  // Reference behaviour from plain 64-bit arithmetic on the operand values.
  function automatic expect_t refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    expect_t         e;
    longint unsigned ua, ub, ur;
    longint          sa, sb, sr;
    int              sh;
    ua = a; ub = b;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    ur = 0; sr = 0;
    e.res = '0; e.ov = 1'b0; e.c = 1'b0; e.lat = 1;
    case (op)
      OP_ADD: begin
        ur = ua + ub; e.res = ur[31:0]; e.c = ur[32];
        sr = sa + sb; e.ov = (sr > SMAX) || (sr < SMIN);
      end
      OP_SUB: begin
        ur = ua - ub; e.res = ur[31:0]; e.c = (ua >= ub);
        sr = sa - sb; e.ov = (sr > SMAX) || (sr < SMIN);
      end
      OP_XOR:  e.res = a ^ b;
      OP_SLT:  e.res = (sa < sb) ? 32'd1 : 32'd0;
      OP_AND:  e.res = a & b;
      OP_NAND: e.res = ~(a & b);
      OP_NOR:  e.res = ~(a | b);
      OP_OR:   e.res = a | b;
      OP_MUL: begin
        ur = ua * ub; e.res = ur[31:0]; e.ov = ((ur >> 32) != 0); e.lat = 32;
      end
      OP_SLL: begin ur = ua << sh; e.res = ur[31:0]; end
      OP_SRL: e.res = a >> sh;
      OP_SRA: begin sr = sa >>> sh; e.res = sr[31:0]; end
      default: e.res = '0;
    endcase
    e.z = (op < 4'd12) && (e.res == 32'd0);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input longint unsigned observed, input longint unsigned expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Called on a negedge; returns on the posedge that accepts the op.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard;
    guard = 0;
    bus32.in_valid = 1'b1;
    bus32.op = op; bus32.a = a; bus32.b = b;
    #1;
    while (!bus32.in_ready && guard < 100) begin
      @(negedge clk); #1; guard++;
    end
    checkOutput("accept.in_ready", bus32.in_ready, 1);
    @(posedge clk);
  endtask

  task automatic runAndCheck(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    expect_t e;
    int      lat;
    e = refModel(op, a, b);
    applyStimulus(op, a, b);
    @(negedge clk);
    bus32.in_valid = 1'b0;
    lat = 1;
    while (!bus32.out_valid && lat < 100) begin
      @(negedge clk); lat++;
    end
    checkOutput({tag, ".lat"},  lat,             e.lat);
    checkOutput({tag, ".res"},  bus32.result,    e.res);
    checkOutput({tag, ".zero"}, bus32.zero,      e.z);
    checkOutput({tag, ".ovf"},  bus32.overflow,  e.ov);
    checkOutput({tag, ".cout"}, bus32.cout,      e.c);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        sawValid;
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    bus32.in_valid = 1'b0; bus32.op = '0; bus32.a = '0; bus32.b = '0; bus32.out_ready = 1'b1;
    bus8.in_valid  = 1'b0; bus8.op  = '0; bus8.a  = '0; bus8.b  = '0; bus8.out_ready  = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("rst.out_valid", bus32.out_valid, 0);
    checkOutput("rst.in_ready",  bus32.in_ready,  1);
    checkOutput("rst.result",    bus32.result,    0);
    checkOutput("rst.zero",      bus32.zero,      0);
    checkOutput("rst.ovf",       bus32.overflow,  0);
    checkOutput("rst.cout",      bus32.cout,      0);
    rst_n = 1'b1;
    @(negedge clk);

    runAndCheck("add_0_1",    OP_ADD, 32'h0,        32'h1);
    checkOutput("add_0_1.lit", bus32.result, 32'h1);
    runAndCheck("add_ovf",    OP_ADD, 32'h7FFFFFFF, 32'h1);
    checkOutput("add_ovf.lit", bus32.overflow, 1);
    runAndCheck("add_carry",  OP_ADD, 32'hFFFFFFFF, 32'h1);
    checkOutput("add_carry.lit", bus32.cout, 1);
    runAndCheck("sub_eq",     OP_SUB, 32'd5,        32'd5);
    runAndCheck("mul_big",    OP_MUL, 32'h10000,    32'h10000);
    runAndCheck("mul_small",  OP_MUL, 32'd1234,     32'd5678);
    checkOutput("mul_small.lit", bus32.result, 32'd7006652);
    runAndCheck("illegal_e",  4'hE,   32'h1234,     32'h5678);
    runAndCheck("sll_0",      OP_SLL, 32'hDEADBEEF, 32'd32);

    // Backpressure: hold the SRA result, then chain an SLT with no bubble.
    @(negedge clk);
    bus32.out_ready = 1'b0;
    applyStimulus(OP_SRA, 32'h80000000, 32'd35);
    @(negedge clk);
    bus32.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp.result",    bus32.result,    32'hF0000000);
      checkOutput("bp.in_ready",  bus32.in_ready,  0);
      checkOutput("bp.out_valid", bus32.out_valid, 1);
      @(negedge clk);
    end
    bus32.out_ready = 1'b1;
    bus32.in_valid = 1'b1; bus32.op = OP_SLT; bus32.a = 32'hFFFFFFFF; bus32.b = 32'h0;
    #1;
    checkOutput("bp.ready_up", bus32.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus32.in_valid = 1'b0;
    checkOutput("bp.slt_valid",  bus32.out_valid, 1);
    checkOutput("bp.slt_result", bus32.result,    32'h1);

    // Reset in the middle of a multiply.
    @(negedge clk);
    applyStimulus(OP_MUL, 32'd3, 32'd7);
    @(negedge clk);
    bus32.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mrst.out_valid", bus32.out_valid, 0);
    checkOutput("mrst.result",    bus32.result,    0);
    checkOutput("mrst.zero",      bus32.zero,      0);
    checkOutput("mrst.ovf",       bus32.overflow,  0);
    checkOutput("mrst.cout",      bus32.cout,      0);
    @(negedge clk);
    rst_n = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus32.out_valid) sawValid = 1'b1;
    end
    checkOutput("mrst.no_result", sawValid,       0);
    checkOutput("mrst.in_ready",  bus32.in_ready, 1);

    // Random ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      if ((i % 4) == 1) rb = 32'($urandom_range(0, 40));
      if ((i % 8) == 3) ra = 32'h80000000 >> $urandom_range(0, 2);
      runAndCheck("rand", rop, ra, rb);
    end

    // Narrow build: shift amount wraps modulo 8.
    @(negedge clk);
    bus8.in_valid = 1'b1; bus8.op = OP_SLL; bus8.a = 8'h81; bus8.b = 8'd9;
    #1;
    checkOutput("w8.in_ready", bus8.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    checkOutput("w8.out_valid", bus8.out_valid, 1);
    checkOutput("w8.result",    bus8.result,    8'h02);
    checkOutput("w8.zero",      bus8.zero,      0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 32-bit combinational ALU.
- Same 3-bit base op set, extended to a 4-bit opcode: barrel shifts plus a multi-cycle shift-add multiplier.
- Valid/ready handshakes on input and output, so it sits directly between the operand-fetch stage and the writeback stage of the CPU datapath.
- Result and flags (zero, overflow, cout) are registered and held until consumed.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 4..64.
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  block accepts a new op this cycle.
- op  input  4  opcode (see Behaviour).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B (shift amount = b[SHW-1:0] for shifts).
- out_valid  output  1  result/flags are valid.
- out_ready  input  1  consumer takes result this cycle.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0.
- overflow  output  1  signed overflow (ADD/SUB); upper-half-nonzero (MUL); else 0.
- cout  output  1  carry out (ADD); not-borrow, i.e. a>=b unsigned (SUB); else 0.

Behaviour:
- Reset (async assert, sync-released by the clock edge): state IDLE; result=0, zero=0, overflow=0, cout=0, out_valid=0, in_ready=1; multiplier registers cleared.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 XOR, 0011 SLT (result=1 if signed a<b), 0100 AND, 0101 NAND, 0110 NOR, 0111 OR.
  - 1000 MUL: unsigned, low WIDTH bits.
  - 1001 SLL, 1010 SRL, 1011 SRA.
  - 1100-1111 illegal: result=0, all flags 0, single-cycle latency, no error signal.
- Accept: handshake when in_valid && in_ready.
- States:
  - IDLE: in_ready=1. Single-cycle op → HOLD next cycle, result registered (latency 1). MUL → MBUSY, load multiplicand/multiplier, count=0.
  - MBUSY: in_ready=0. One shift-add step per cycle over WIDTH cycles, using a 2*WIDTH product accumulator. On the step where count==WIDTH-1, go to HOLD with the low half in result; overflow = |upper half. Accept-to-out_valid latency = WIDTH cycles.
  - HOLD: out_valid=1; result/flags stable until out_ready.
    - out_ready && in_valid: new op accepted the same cycle (in_ready=out_ready in HOLD) → back-to-back throughput 1/cycle for single-cycle ops.
    - out_ready && !in_valid: → IDLE, out_valid=0.
- Flags computed from the WIDTH-bit result only. zero is 1 for an all-zero MUL low half even if overflow=1.
- Shifts: amount taken modulo WIDTH (upper b bits ignored). Shift by 0 returns a unchanged.
- in_valid without in_ready: inputs ignored; the producer must hold them.
- Inputs are sampled at acceptance only; later changes during MBUSY are ignored.
- rst_n asserted in any state (including mid-MUL): op abandoned, outputs return to reset values immediately, no result emitted.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_ADD..OP_SRA;
  - state encoding IDLE/MBUSY/HOLD;
  - a flag-bundle typedef {zero, overflow, cout}.
- One sub-module, alu_comb: purely combinational single-cycle datapath (ADD..SRA, illegal → 0, flag generation), parametrised by WIDTH.
- alu_seq holds the FSM, the multiplier, and the output registers.

Test Plan:
- WIDTH=32, ADD a=0, b=1, out_ready=1 → out_valid one cycle after accept; result=1, zero=0, overflow=0, cout=0.
- ADD a=0x7FFFFFFF, b=1 → result=0x80000000, overflow=1, cout=0.
- ADD a=0xFFFFFFFF, b=1 → result=0, zero=1, cout=1.
- SUB a=5, b=5 → result=0, zero=1, cout=1.
- MUL a=0x10000, b=0x10000 → out_valid exactly 32 cycles after accept; result=0, zero=1, overflow=1.
- MUL a=1234, b=5678 → result=7006652, overflow=0.
- MUL a=3 accepted, then rst_n asserted on cycle 10 → out_valid stays 0; all outputs 0; in_ready=1 after release.
- Backpressure: SRA a=0x80000000, b=35 (→ shift 3), out_ready held 0 for 5 cycles:
  - result=0xF0000000 stable throughout; in_ready=0.
  - Raise out_ready with a new valid SLT a=-1, b=0 → the next cycle shows result=1, with no bubble.
- Illegal op 1110 → result=0, flags 0, latency 1.
- WIDTH=8 build: SLL a=0x81, b=9 → result=0x02.
